// File: rtl/pc_ras_unit.sv
// Fetch-stage program counter with prioritised redirects (trap > jump > return > sequential),
// optional compressed stepping, misaligned-jump detection and a circular return-address stack.
module pc_ras_unit #(
    parameter int unsigned     XLEN             = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR     = '0,
    parameter int unsigned     RAS_DEPTH        = 4,
    parameter bit              ALLOW_COMPRESSED = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       trap_valid,
    input  logic [XLEN-1:0]            trap_target,
    input  logic                       jump_enable,
    input  logic [XLEN-1:0]            jump_address,
    input  logic                       ret_enable,
    input  logic                       call_enable,
    input  logic                       inst_compressed,
    output logic [XLEN-1:0]            pc_address_out,
    output logic                       ras_empty,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       misaligned,
    output logic [XLEN-1:0]            misaligned_addr
);

    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [XLEN-1:0] AlignMask = ALLOW_COMPRESSED ? XLEN'(1) : XLEN'(3);
    localparam logic [CntW-1:0] CntFull   = CntW'(RAS_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [XLEN-1:0] ras_d [RAS_DEPTH];
    logic [PtrW-1:0] top_q, top_d;
    logic [CntW-1:0] count_q, count_d;
    logic            mis_q, mis_d;
    logic [XLEN-1:0] mis_addr_q, mis_addr_d;

    logic [XLEN-1:0] inc;
    logic [XLEN-1:0] seq;
    logic [PtrW-1:0] top_inc;
    logic [PtrW-1:0] top_dec;
    logic            empty;
    logic            full;
    logic            jump_misaligned;
    logic            do_pop;

    assign inc     = (ALLOW_COMPRESSED && inst_compressed) ? XLEN'(2) : XLEN'(4);
    assign seq     = pc_q + inc;
    assign top_inc = top_q + PtrW'(1);
    assign top_dec = top_q - PtrW'(1);
    assign empty   = (count_q == '0);
    assign full    = (count_q == CntFull);

    assign jump_misaligned = jump_enable && ((jump_address & AlignMask) != '0);
    // A jump outranks a return, so the RAS is only popped when no jump is requested.
    assign do_pop          = ret_enable && !jump_enable && !empty;

    always_comb begin
        pc_d       = pc_q;
        top_d      = top_q;
        count_d    = count_q;
        ras_d      = ras_q;
        mis_d      = 1'b0;
        mis_addr_d = mis_addr_q;

        if (trap_valid) begin
            pc_d    = trap_target & ~AlignMask;
            top_d   = '0;
            count_d = '0;
        end else if (!stall) begin
            if (jump_misaligned) begin
                mis_d      = 1'b1;
                mis_addr_d = jump_address;
            end else begin
                if (jump_enable) begin
                    pc_d = jump_address;
                end else if (do_pop) begin
                    pc_d = ras_q[top_q];
                end else begin
                    pc_d = seq;
                end

                if (call_enable && do_pop) begin
                    // Return consumes the top while the call refills it: depth unchanged.
                    ras_d[top_q] = seq;
                end else if (call_enable) begin
                    // When full, top_inc lands on the oldest entry and overwrites it.
                    top_d          = top_inc;
                    ras_d[top_inc] = seq;
                    if (!full) begin
                        count_d = count_q + CntW'(1);
                    end
                end else if (do_pop) begin
                    top_d   = top_dec;
                    count_d = count_q - CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_VECTOR;
            top_q      <= '0;
            count_q    <= '0;
            mis_q      <= 1'b0;
            mis_addr_q <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            top_q      <= top_d;
            count_q    <= count_d;
            mis_q      <= mis_d;
            mis_addr_q <= mis_addr_d;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_q[i] <= ras_d[i];
            end
        end
    end

    assign pc_address_out  = pc_q;
    assign ras_count       = count_q;
    assign ras_empty       = empty;
    assign misaligned      = mis_q;
    assign misaligned_addr = mis_addr_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed bench for pc_ras_unit: one instance without and one with compressed support,
// both driven from the same inputs.
module tb_pc_ras_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        trap_valid;
    logic [31:0] trap_target;
    logic        jump_enable;
    logic [31:0] jump_address;
    logic        ret_enable;
    logic        call_enable;
    logic        inst_compressed;

    logic [31:0] pc0, pc1, mis_addr0, mis_addr1;
    logic [2:0]  cnt0, cnt1;
    logic        empty0, empty1, mis0, mis1;

    int n_checks;
    int n_errors;

    pc_ras_unit #(
        .XLEN            (32),
        .RESET_VECTOR    (32'h0000_0100),
        .RAS_DEPTH       (4),
        .ALLOW_COMPRESSED(1'b0)
    ) u_dut0 (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .trap_valid     (trap_valid),
        .trap_target    (trap_target),
        .jump_enable    (jump_enable),
        .jump_address   (jump_address),
        .ret_enable     (ret_enable),
        .call_enable    (call_enable),
        .inst_compressed(inst_compressed),
        .pc_address_out (pc0),
        .ras_empty      (empty0),
        .ras_count      (cnt0),
        .misaligned     (mis0),
        .misaligned_addr(mis_addr0)
    );

    pc_ras_unit #(
        .XLEN            (32),
        .RESET_VECTOR    (32'h0000_0100),
        .RAS_DEPTH       (4),
        .ALLOW_COMPRESSED(1'b1)
    ) u_dut1 (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .trap_valid     (trap_valid),
        .trap_target    (trap_target),
        .jump_enable    (jump_enable),
        .jump_address   (jump_address),
        .ret_enable     (ret_enable),
        .call_enable    (call_enable),
        .inst_compressed(inst_compressed),
        .pc_address_out (pc1),
        .ras_empty      (empty1),
        .ras_count      (cnt1),
        .misaligned     (mis1),
        .misaligned_addr(mis_addr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall        = 1'b0;
        trap_valid   = 1'b0;
        trap_target  = '0;
        jump_enable  = 1'b0;
        jump_address = '0;
        ret_enable   = 1'b0;
        call_enable  = 1'b0;
        inst_compressed = 1'b0;
    endtask

    task automatic trap_to(input logic [31:0] tgt);
        trap_valid  = 1'b1;
        trap_target = tgt;
        step();
        trap_valid  = 1'b0;
    endtask

    task automatic call_jump(input logic [31:0] tgt);
        call_enable  = 1'b1;
        jump_enable  = 1'b1;
        jump_address = tgt;
        step();
        call_enable  = 1'b0;
        jump_enable  = 1'b0;
    endtask

    task automatic do_ret();
        ret_enable = 1'b1;
        step();
        ret_enable = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        rst = 1'b0;
        #12;
        check_eq("rst_pc", pc0, 32'h100);
        check_eq("rst_empty", 32'(empty0), 32'd1);
        check_eq("rst_count", 32'(cnt0), 32'd0);
        check_eq("rst_mis", 32'(mis0), 32'd0);
        check_eq("rst_mis_addr", mis_addr0, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        step();
        check_eq("seq_1", pc0, 32'h104);
        step();
        check_eq("seq_2", pc0, 32'h108);
        check_eq("seq_empty", 32'(empty0), 32'd1);

        stall = 1'b1;
        step(); step(); step();
        check_eq("stall_hold", pc0, 32'h108);
        trap_to(32'h203);
        stall = 1'b0;
        check_eq("trap_over_stall", pc0, 32'h200);
        check_eq("trap_count", 32'(cnt0), 32'd0);
        check_eq("trap_mask_c", pc1, 32'h202);

        // Call/return basics.
        trap_to(32'h10);
        call_jump(32'h80);
        check_eq("call_pc", pc0, 32'h80);
        check_eq("call_count", 32'(cnt0), 32'd1);
        do_ret();
        check_eq("ret_pc", pc0, 32'h14);
        check_eq("ret_count", 32'(cnt0), 32'd0);
        do_ret();
        check_eq("ret_empty_pc", pc0, 32'h18);
        check_eq("ret_empty_flag", 32'(empty0), 32'd1);

        // Priority.
        call_jump(32'h40);
        trap_valid = 1'b1; trap_target = 32'h300;
        jump_enable = 1'b1; jump_address = 32'h500; ret_enable = 1'b1;
        step();
        idle_inputs();
        check_eq("prio_trap_pc", pc0, 32'h300);
        check_eq("prio_trap_flush", 32'(cnt0), 32'd0);
        call_jump(32'h600);
        jump_enable = 1'b1; jump_address = 32'h700; ret_enable = 1'b1;
        step();
        idle_inputs();
        check_eq("prio_jump_pc", pc0, 32'h700);
        check_eq("prio_jump_nopop", 32'(cnt0), 32'd1);
        do_ret();
        check_eq("prio_ret_top", pc0, 32'h304);

        // Call and return together.
        call_jump(32'h800);
        call_enable = 1'b1; ret_enable = 1'b1;
        step();
        idle_inputs();
        check_eq("callret_pc", pc0, 32'h308);
        check_eq("callret_count", 32'(cnt0), 32'd1);
        do_ret();
        check_eq("callret_top", pc0, 32'h804);
        call_enable = 1'b1; ret_enable = 1'b1;
        step();
        idle_inputs();
        check_eq("callret_empty_pc", pc0, 32'h808);
        check_eq("callret_empty_cnt", 32'(cnt0), 32'd1);
        do_ret();
        check_eq("callret_empty_pop", pc0, 32'h808);

        // Overflow: five calls into a 4-deep stack.
        trap_to(32'h0);
        call_jump(32'h100);
        call_jump(32'h200);
        call_jump(32'h300);
        call_jump(32'h400);
        call_jump(32'h900);
        check_eq("ovf_count", 32'(cnt0), 32'd4);
        do_ret();
        check_eq("ovf_ret1", pc0, 32'h404);
        do_ret();
        check_eq("ovf_ret2", pc0, 32'h304);
        do_ret();
        check_eq("ovf_ret3", pc0, 32'h204);
        do_ret();
        check_eq("ovf_ret4", pc0, 32'h104);
        check_eq("ovf_empty", 32'(empty0), 32'd1);
        do_ret();
        check_eq("ovf_ret5_seq", pc0, 32'h108);

        // Misaligned jump, including a suppressed call push.
        jump_enable = 1'b1; jump_address = 32'h1002;
        step();
        idle_inputs();
        check_eq("mis_pc_hold", pc0, 32'h108);
        check_eq("mis_pulse", 32'(mis0), 32'd1);
        check_eq("mis_addr", mis_addr0, 32'h1002);
        step();
        check_eq("mis_pulse_end", 32'(mis0), 32'd0);
        check_eq("mis_addr_held", mis_addr0, 32'h1002);
        check_eq("mis_after_pc", pc0, 32'h10c);
        call_jump(32'h2001);
        check_eq("mis_call_nopush", 32'(cnt0), 32'd0);
        check_eq("mis_call_pc", pc0, 32'h10c);
        check_eq("mis_addr2", mis_addr0, 32'h2001);

        // Wrap-around.
        trap_to(32'hFFFF_FFFC);
        step();
        check_eq("wrap", pc0, 32'h0);

        // Asynchronous reset without a clock edge.
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_rst_pc", pc0, 32'h100);
        check_eq("async_rst_mis_addr", mis_addr0, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Compressed stepping and alignment.
        inst_compressed = 1'b1;
        step();
        inst_compressed = 1'b0;
        check_eq("c_step_2", pc1, 32'h102);
        check_eq("nc_step_4", pc0, 32'h104);
        jump_enable = 1'b1; jump_address = 32'h1002;
        step();
        idle_inputs();
        check_eq("c_jump_ok", pc1, 32'h1002);
        check_eq("c_no_mis", 32'(mis1), 32'd0);
        check_eq("nc_jump_hold", pc0, 32'h104);
        check_eq("nc_mis", 32'(mis0), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
Parametrised next-generation program counter for the fetch stage. It generates the fetch address with prioritised redirects (trap > jump > return > sequential) and a global stall. It adds optional compressed-instruction stepping, misaligned-target detection, and an internal return-address stack (RAS) that predicts return targets. The block sits at the head of the fetch pipeline and drives the instruction-memory address.

Parameters:
XLEN, 32, width of the PC and all address ports.
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset. Must be aligned.
RAS_DEPTH, 4, number of RAS entries. Must be a power of two, at least 2.
ALLOW_COMPRESSED, 0, when 1 enables 2-byte stepping and 2-byte alignment.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
stall  in  1  holds the PC and the RAS when 1.
trap_valid  in  1  trap redirect request.
trap_target  in  XLEN  trap handler address.
jump_enable  in  1  branch/jump redirect request.
jump_address  in  XLEN  branch/jump target.
ret_enable  in  1  current instruction is a return; predict from the RAS.
call_enable  in  1  current instruction is a call; push the return address.
inst_compressed  in  1  current instruction is 16-bit. Ignored when ALLOW_COMPRESSED=0.
pc_address_out  out  XLEN  current fetch PC.
ras_empty  out  1  RAS holds no entries.
ras_count  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries.
misaligned  out  1  one-cycle pulse: jump target was misaligned.
misaligned_addr  out  XLEN  offending jump target, held until the next misalignment.

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_VECTOR, ras_count=0, ras_empty=1, misaligned=0, misaligned_addr=0. All RAS entries are cleared to 0.
- inc = 2 when ALLOW_COMPRESSED=1 and inst_compressed=1; otherwise inc = 4. seq = pc+inc, modulo 2^XLEN (wrap-around, no flag).
- Alignment mask: low 2 bits must be zero when ALLOW_COMPRESSED=0; low bit must be zero when ALLOW_COMPRESSED=1.
- Priority evaluated at each rising edge:
  1. trap_valid=1:
     - pc <= trap_target with its misaligned low bits forced to 0.
     - The RAS is flushed (count 0).
     - stall, jump, ret and call are ignored.
     - A trap overrides stall.
  2. If stall=1 (and no trap): pc, the RAS and misaligned_addr hold; misaligned=0.
  3. jump_enable=1, target aligned: pc <= jump_address.
  4. jump_enable=1, target misaligned: pc holds; misaligned=1 for the next cycle; misaligned_addr <= jump_address; call push is suppressed.
  5. ret_enable=1 and RAS not empty: pc <= top entry; pop.
  6. ret_enable=1 and RAS empty: pc <= seq; no pop.
  7. Otherwise: pc <= seq.
- Call push: when call_enable=1, no trap, no stall, and no misaligned jump, push seq (computed from the pre-update pc). This applies whichever source selected the next pc.
- Call and return in the same cycle with the RAS non-empty: pc takes the old top entry; the top is replaced with seq; count is unchanged.
- Call and return in the same cycle with the RAS empty: sequential pc; push only.
- Push when full (count=RAS_DEPTH): circular overwrite of the oldest entry; count stays saturated at RAS_DEPTH.
- Pop decrements count. The RAS is a circular buffer with a top pointer modulo RAS_DEPTH.
- pc_address_out = pc, registered, with zero combinational path from inputs. ras_empty = (ras_count==0).
- Latency: every redirect becomes visible on pc_address_out one cycle after the edge that samples it.
- rst asserted mid-operation returns everything to reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset and step: rst low, then high with RESET_VECTOR=0x100 → pc 0x100, 0x104, 0x108 on successive edges; ras_empty=1.
- Stall and trap: stall=1 for 3 cycles → pc holds. Then stall=1 with trap_valid=1 and trap_target=0x203 → pc=0x200 and ras_count=0.
- Priority: trap, jump and ret all asserted → trap_target taken. Jump and ret asserted (RAS non-empty) → jump_address taken; RAS not popped.
- RAS call/return: at pc=0x10 call with jump to 0x80 → pc=0x80, ras_count=1. Then ret → pc=0x14, ras_count=0. A further ret → pc=0x18.
- RAS overflow: RAS_DEPTH=4, five calls from pcs 0x0, 0x100, 0x200, 0x300, 0x400 → ras_count=4. Four returns yield 0x404, 0x304, 0x204, 0x104, then ras_empty=1.
- Misaligned and wrap:
  - ALLOW_COMPRESSED=0, jump to 0x1002 → pc holds, misaligned pulse for 1 cycle, misaligned_addr=0x1002.
  - ALLOW_COMPRESSED=1, jump to 0x1002 → accepted.
  - pc=0xFFFF_FFFC, sequential step → pc=0x0000_0000.
